// File: rtl/capture_ctrl.sv
// capture_ctrl: oscilloscope acquisition sequencer.
//   Paces ADC sampling from a latched timebase, arms a level/slope trigger,
//   writes 2**ADDR_W consecutive samples to the frame RAM, then holds the
//   finished frame until the display side acknowledges it.
// Optional feature: define CAPTURE_AUTO_TRIG_EN to force a trigger after
//   AUTO_TO sample strobes in ARMED without a real edge.
// Ports:
//   sys_clk, rst           clock, synchronous active-high reset
//   td, trig_level,        timebase / trigger setup, latched on arm
//   trig_slope
//   arm, stop, frame_ack   control pulses
//   adc_data               ADC sample, used on strobe cycles only
//   wr_en/wr_addr/wr_data  registered frame RAM write port
//   busy, triggered,       registered status
//   frame_ready
`timescale 1ns/1ps

module capture_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DIV_BASE = 8,
  parameter int unsigned AUTO_TO  = 1024
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic [1:0]        td,
  input  logic              arm,
  input  logic              stop,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              triggered,
  output logic              frame_ready
);

  // Largest period is DIV_BASE << 3, so P-1 always fits in CNT_W bits.
  localparam int unsigned      CNT_W     = $clog2(DIV_BASE * 8);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_td;
  logic [DATA_W-1:0]   r_level;
  logic                r_slope;
  logic [DATA_W-1:0]   r_prev;
  logic                r_prev_valid;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_triggered;
  logic                r_frame_ready;

  logic [CNT_W-1:0]    w_per_m1;
  logic                w_strobe;
  logic                w_edge;
  logic                w_timeout;
  logic                w_fire;
  logic [ADDR_W-1:0]   w_next_addr;

  assign w_per_m1    = CNT_W'((DIV_BASE << r_td) - 32'd1);
  assign w_strobe    = ((r_state == S_ARMED) || (r_state == S_CAPTURE)) && (r_cnt == w_per_m1);
  // The first strobe after arm only primes r_prev, so it can never fire.
  assign w_edge      = r_prev_valid &&
                       (r_slope ? ((r_prev > r_level) && (adc_data <= r_level))
                                : ((r_prev < r_level) && (adc_data >= r_level)));
  assign w_fire      = w_edge || w_timeout;
  assign w_next_addr = r_wr_addr + 1'b1;

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int unsigned ACNT_W = $clog2(AUTO_TO + 1);
  logic [ACNT_W-1:0] r_acnt;

  // Counts ARMED strobes; the AUTO_TO-th one is treated as the trigger.
  assign w_timeout = (r_acnt == ACNT_W'(AUTO_TO - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_acnt <= '0;
    end else if ((r_state == S_IDLE) && arm && !stop) begin
      r_acnt <= '0;
    end else if ((r_state == S_ARMED) && w_strobe && !stop) begin
      r_acnt <= r_acnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_td          <= '0;
      r_level       <= '0;
      r_slope       <= 1'b0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_busy        <= 1'b0;
      r_triggered   <= 1'b0;
      r_frame_ready <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (arm && !stop) begin
            r_state      <= S_ARMED;
            r_cnt        <= '0;
            r_td         <= td;
            r_level      <= trig_level;
            r_slope      <= trig_slope;
            r_prev_valid <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (stop) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_triggered <= 1'b0;
          end else begin
            r_cnt <= w_strobe ? '0 : r_cnt + 1'b1;
            if (w_strobe) begin
              if (r_state == S_ARMED) begin
                r_prev       <= adc_data;
                r_prev_valid <= 1'b1;
                if (w_fire) begin
                  r_state     <= S_CAPTURE;
                  r_triggered <= 1'b1;
                  r_wr_en     <= 1'b1;
                  r_wr_addr   <= '0;
                  r_wr_data   <= adc_data;
                end
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_next_addr;
                r_wr_data <= adc_data;
                if (w_next_addr == LAST_ADDR) begin
                  r_state       <= S_DONE;
                  r_busy        <= 1'b0;
                  r_frame_ready <= 1'b1;
                end
              end
            end
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            r_state       <= S_IDLE;
            r_frame_ready <= 1'b0;
            r_triggered   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign triggered   = r_triggered;
  assign frame_ready = r_frame_ready;

endmodule

// File: tb/tb_capture_ctrl.sv
`timescale 1ns/1ps

module tb_capture_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int JS    = 40;    // strobes searched for a trigger in a random trial
  localparam int L     = 4096;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    td = '0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_slope = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          frame_ack = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          triggered;
  logic          frame_ready;
  logic [3:0]    w_flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] adcv [0:L-1];

  always #5 sys_clk = ~sys_clk;

  assign w_flags = {wr_en, busy, triggered, frame_ready};

  capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DIV_BASE(8), .AUTO_TO(1024)) dut (
    .sys_clk(sys_clk), .rst(rst), .td(td), .arm(arm), .stop(stop),
    .trig_level(trig_level), .trig_slope(trig_slope), .adc_data(adc_data),
    .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .triggered(triggered), .frame_ready(frame_ready)
  );

  typedef struct {
    logic       slope;
    logic [7:0] lvl;
    logic [7:0] prev;
    logic [7:0] cur;
    logic       exp;
  } vec_t;
  vec_t vt [13];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge with the given ADC value; single-cycle pulses drop afterwards.
  task automatic hstep(input logic [7:0] d);
    adc_data = d;
    tick();
    arm = 1'b0;
    stop = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic start_arm(input logic [1:0] t, input logic [7:0] lvl, input logic slp,
                           input logic [7:0] d);
    td = t;
    trig_level = lvl;
    trig_slope = slp;
    arm = 1'b1;
    hstep(d);
  endtask

  function automatic bit fires(input logic slp, input logic [7:0] lvl,
                               input logic [7:0] p, input logic [7:0] c);
    return slp ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
  endfunction

  function automatic logic [7:0] ramp_val(input int j);
    if (j <= 1) return 8'h70;
    if (j == 2) return 8'h78;
    return 8'(8'h88 + 8 * (j - 3));
  endfunction

  // Full acquisition against a reference built from the strobe timeline:
  // strobe j samples the ADC at arm-edge offset P*j.
  task automatic run_trial(input logic [1:0] t, input logic [7:0] lvl, input logic slp,
                           input bit ramp);
    int p, jt, done_o, o_last;
    bit ew, eb, et, ef;
    p = 8 << t;
    for (int o = 0; o < L; o++)
      adcv[o] = ramp ? ramp_val((o + p - 1) / p) : 8'($urandom);
    jt = 0;
    for (int j = 2; j <= JS; j++)
      if (jt == 0 && fires(slp, lvl, adcv[p * (j - 1)], adcv[p * j])) jt = j;
    done_o = p * (jt + DEPTH - 1);
    o_last = (jt > 0) ? done_o + 4 : p * JS;
    for (int o = 0; o <= o_last; o++) begin
      if (o == 0) begin
        arm = 1'b1; td = t; trig_level = lvl; trig_slope = slp; frame_ack = 1'b0;
      end else begin
        // Latched settings must ignore these; arm and early acks must be ignored too.
        arm = 1'($urandom);
        td = 2'($urandom);
        trig_level = 8'($urandom);
        trig_slope = 1'($urandom);
        frame_ack = (jt == 0 || o <= done_o) ? 1'($urandom) : 1'b0;
      end
      adc_data = adcv[o];
      tick();
      ew = (jt > 0) && (o >= p * jt) && (o <= done_o) && (o % p == 0);
      eb = (jt == 0) || (o < done_o);
      et = (jt > 0) && (o >= p * jt);
      ef = (jt > 0) && (o >= done_o);
      chk("trial_flags", w_flags, {ew, eb, et, ef});
      if (ew) chk("trial_wdata", {wr_addr, wr_data}, {4'(o / p - jt), adcv[o]});
    end
    arm = 1'b0;
    if (jt > 0) frame_ack = 1'b1;
    else stop = 1'b1;
    hstep(8'h00);
    chk("trial_end", w_flags, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      hstep(8'($urandom));
      chk("trial_idle", w_flags, 4'b0000);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 8'h80, 8'h7F, 8'h80, 1'b1};
    vt[1]  = '{1'b0, 8'h80, 8'h80, 8'h81, 1'b0};
    vt[2]  = '{1'b0, 8'h80, 8'h70, 8'hFF, 1'b1};
    vt[3]  = '{1'b0, 8'h80, 8'h7F, 8'h7F, 1'b0};
    vt[4]  = '{1'b0, 8'h80, 8'h00, 8'h80, 1'b1};
    vt[5]  = '{1'b1, 8'h40, 8'h50, 8'h40, 1'b1};
    vt[6]  = '{1'b1, 8'h40, 8'h41, 8'h3F, 1'b1};
    vt[7]  = '{1'b1, 8'h40, 8'h40, 8'h00, 1'b0};
    vt[8]  = '{1'b1, 8'h40, 8'h41, 8'h41, 1'b0};
    vt[9]  = '{1'b1, 8'h40, 8'hFF, 8'h40, 1'b1};
    vt[10] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0};
    vt[11] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vt[12] = '{1'b0, 8'hFF, 8'hFE, 8'hFF, 1'b1};

    rst = 1'b1;
    tick();
    tick();
    chk("reset", {w_flags, wr_addr, wr_data}, 32'd0);
    rst = 1'b0;

    // Trigger decision table: strobe 1 = prev, strobe 2 = cur at P=8.
    for (int i = 0; i < 13; i++) begin
      start_arm(2'd0, vt[i].lvl, vt[i].slope, vt[i].prev);
      for (int o = 1; o <= 8; o++) hstep(vt[i].prev);
      for (int o = 9; o <= 16; o++) hstep(vt[i].cur);
      chk("vec_trig", triggered, vt[i].exp);
      chk("vec_wr_en", wr_en, vt[i].exp);
      if (vt[i].exp) chk("vec_wdata", {wr_addr, wr_data}, {4'd0, vt[i].cur});
      stop = 1'b1;
      hstep(8'h00);
      chk("vec_stop", w_flags, 4'b0000);
    end

    // Stale sample from an aborted run must not pair with the first new strobe.
    start_arm(2'd0, 8'h40, 1'b1, 8'h50);
    for (int o = 1; o <= 8; o++) hstep(8'h50);
    stop = 1'b1;
    hstep(8'h50);
    start_arm(2'd0, 8'h40, 1'b1, 8'h30);
    for (int o = 1; o <= 8; o++) hstep(8'h30);
    chk("first_strobe", {busy, triggered}, 2'b10);
    stop = 1'b1;
    hstep(8'h00);

    // Reset mid-capture (writes at offsets 16, 24, 32 already made).
    start_arm(2'd0, 8'h80, 1'b0, 8'h00);
    for (int o = 1; o <= 15; o++) hstep(8'h00);
    for (int o = 16; o <= 35; o++) hstep(8'hFF);
    chk("pre_rst_trig", {busy, triggered, wr_addr}, {2'b11, 4'd2});
    rst = 1'b1;
    hstep(8'hFF);
    chk("rst_outputs", {w_flags, wr_addr, wr_data}, 32'd0);
    hstep(8'hFF);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      hstep(8'($urandom));
      chk("rst_idle", w_flags, 4'b0000);
    end

    // Stop exactly on the strobe that would write address 6.
    start_arm(2'd0, 8'h80, 1'b0, 8'h00);
    for (int o = 1; o <= 15; o++) hstep(8'h00);
    for (int o = 16; o <= 63; o++) begin
      hstep(8'hFF);
      if (o == 56) chk("addr5", {wr_en, wr_addr}, {1'b1, 4'd5});
    end
    stop = 1'b1;
    hstep(8'hFF);
    chk("stop_cap", w_flags, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      hstep(8'hFF);
      chk("stop_idle", w_flags, 4'b0000);
    end

    // arm and stop together in IDLE.
    arm = 1'b1;
    stop = 1'b1;
    trig_level = 8'h80;
    hstep(8'h00);
    chk("arm_stop", w_flags, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      hstep((i < 10) ? 8'h00 : 8'hFF);
      chk("arm_stop_idle", w_flags, 4'b0000);
    end

    run_trial(2'd0, 8'h80, 1'b0, 1'b1);     // ramp, trigger on 0x88
    run_trial(2'd3, 8'h80, 1'b0, 1'b0);     // 64-cycle spacing, td scrambled later
    run_trial(2'd1, 8'h40, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      run_trial(2'($urandom), 8'($urandom_range(16, 240)), 1'($urandom), 1'b0);

`ifdef CAPTURE_AUTO_TRIG_EN
    start_arm(2'd0, 8'h80, 1'b0, 8'h00);
    for (int o = 1; o <= 8192; o++) begin
      hstep(8'h00);
      if (o == 8191) chk("auto_pre", triggered, 1'b0);
    end
    chk("auto_trig", {wr_en, triggered, wr_addr, wr_data}, {2'b11, 4'd0, 8'h00});
    stop = 1'b1;
    hstep(8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
